// File: rtl/des_pkg.sv
// Shared DES S-box constants: the eight substitution tables, box count and serial FSM states.
package des_pkg;

    localparam int unsigned NUM_BOXES = 8;
    localparam int unsigned BOX_IDX_W = 3;
    localparam int unsigned GRP_W     = 6;
    localparam int unsigned RES_W     = 4;
    localparam int unsigned IN_W      = NUM_BOXES * GRP_W;
    localparam int unsigned OUT_W     = NUM_BOXES * RES_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ser_state_e;

    // One 256-bit word per box; entry row*16+col sits at nibble (63 - entry), row 0 col 0 is the top nibble.
    localparam logic [255:0] SBOX_TAB [NUM_BOXES] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [RES_W-1:0] sbox_entry(input logic [BOX_IDX_W-1:0] box,
                                                    input logic [GRP_W-1:0]     idx);
        return SBOX_TAB[box][8'(8'd252 - {idx, 2'b00}) +: RES_W];
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// Combinational single S-box lookup: box index plus 6-bit group to 4-bit substitution.
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [BOX_IDX_W-1:0] box_i,
    input  logic [GRP_W-1:0]     grp_i,
    output logic [RES_W-1:0]     res_o
);

    logic [GRP_W-1:0] idx;

    // Row is the outer bit pair, column the inner four bits.
    assign idx   = {grp_i[5], grp_i[0], grp_i[4:1]};
    assign res_o = sbox_entry(box_i, idx);

endmodule

// File: rtl/des_sbox_unit.sv
// Handshaked DES S-box stage (S1..S8), either fully parallel or one shared lookup per cycle.
module des_sbox_unit
    import des_pkg::*;
#(
    parameter bit          SERIAL = 1'b0,
    parameter int unsigned TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] out_data_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);

    if (!SERIAL) begin : g_par
        logic [OUT_W-1:0] lut_res;
        logic [OUT_W-1:0] data_q, data_d;
        logic [TAG_W-1:0] tag_q, tag_d;
        logic             valid_q, valid_d;
        logic             accept;

        for (genvar g = 0; g < NUM_BOXES; g++) begin : g_lut
            des_sbox_lut u_lut (
                .box_i (BOX_IDX_W'(g)),
                .grp_i (in_data_i[IN_W-1-GRP_W*g -: GRP_W]),
                .res_o (lut_res[OUT_W-1-RES_W*g -: RES_W])
            );
        end

        assign accept = in_valid_i && in_ready_o;

        always_comb begin
            data_d  = data_q;
            tag_d   = tag_q;
            valid_d = valid_q;
            if (accept) begin
                data_d  = lut_res;
                tag_d   = in_tag_i;
                valid_d = 1'b1;
            end else if (out_ready_i) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                tag_q   <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                tag_q   <= tag_d;
                valid_q <= valid_d;
            end
        end

        assign in_ready_o  = !valid_q || out_ready_i;
        assign out_valid_o = valid_q;
        assign out_data_o  = data_q;
        assign out_tag_o   = tag_q;
        assign busy_o      = 1'b0;
    end else begin : g_ser
        ser_state_e           state_q, state_d;
        logic [BOX_IDX_W-1:0] cnt_q, cnt_d;
        logic [IN_W-1:0]      shreg_q, shreg_d;
        logic [OUT_W-1:0]     acc_q, acc_d;
        logic [TAG_W-1:0]     tag_q, tag_d;
        logic                 valid_q, valid_d;
        logic                 busy_q, busy_d;
        logic [RES_W-1:0]     lut_res;

        des_sbox_lut u_lut (
            .box_i (cnt_q),
            .grp_i (shreg_q[IN_W-1 -: GRP_W]),
            .res_o (lut_res)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                shreg_q <= '0;
                acc_q   <= '0;
                tag_q   <= '0;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                shreg_q <= shreg_d;
                acc_q   <= acc_d;
                tag_q   <= tag_d;
                valid_q <= valid_d;
                busy_q  <= busy_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: if (in_valid_i) state_d = ST_RUN;
                ST_RUN:  if (cnt_q == BOX_IDX_W'(NUM_BOXES - 1)) state_d = ST_DONE;
                ST_DONE: if (out_ready_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        // Datapath and registered outputs; S1 enters the accumulator first and ends at the top.
        always_comb begin
            cnt_d   = cnt_q;
            shreg_d = shreg_q;
            acc_d   = acc_q;
            tag_d   = tag_q;
            valid_d = valid_q;
            busy_d  = busy_q;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        shreg_d = in_data_i;
                        tag_d   = in_tag_i;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    acc_d   = {acc_q[OUT_W-RES_W-1:0], lut_res};
                    shreg_d = {shreg_q[IN_W-GRP_W-1:0], GRP_W'(0)};
                    if (cnt_q == BOX_IDX_W'(NUM_BOXES - 1)) begin
                        valid_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + BOX_IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready_i) valid_d = 1'b0;
                end
                default: ;
            endcase
        end

        assign in_ready_o  = (state_q == ST_IDLE);
        assign out_valid_o = valid_q;
        assign out_data_o  = acc_q;
        assign out_tag_o   = tag_q;
        assign busy_o      = busy_q;
    end

endmodule

// File: tb/tb_des_sbox_unit.sv
// Directed bench for des_sbox_unit: one parallel and one serial instance checked against hand-computed values.
module tb_des_sbox_unit;

    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic rst_n;

    logic             p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_busy;
    logic [47:0]      p_in_data;
    logic [TAG_W-1:0] p_in_tag, p_out_tag;
    logic [31:0]      p_out_data;

    logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
    logic [47:0]      s_in_data;
    logic [TAG_W-1:0] s_in_tag, s_out_tag;
    logic [31:0]      s_out_data;

    int n_checks = 0;
    int n_pass   = 0;

    // S8 from the DES standard, laid out row by row.
    int s8_tab [4][16] = '{
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7},
        '{ 1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2},
        '{ 7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8},
        '{ 2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    always #5 clk = ~clk;

    des_sbox_unit #(.SERIAL(1'b0), .TAG_W(TAG_W)) u_par (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (p_in_valid),
        .in_ready_o  (p_in_ready),
        .in_data_i   (p_in_data),
        .in_tag_i    (p_in_tag),
        .out_valid_o (p_out_valid),
        .out_ready_i (p_out_ready),
        .out_data_o  (p_out_data),
        .out_tag_o   (p_out_tag),
        .busy_o      (p_busy)
    );

    des_sbox_unit #(.SERIAL(1'b1), .TAG_W(TAG_W)) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (s_in_valid),
        .in_ready_o  (s_in_ready),
        .in_data_i   (s_in_data),
        .in_tag_i    (s_in_tag),
        .out_valid_o (s_out_valid),
        .out_ready_i (s_out_ready),
        .out_data_o  (s_out_data),
        .out_tag_o   (s_out_tag),
        .busy_o      (s_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serial word: accept, then count further edges until out_valid and cycles with busy high.
    task automatic s_run(input logic [47:0] d, input logic [TAG_W-1:0] t,
                         output int lat, output int busy_n);
        s_in_valid = 1'b1;
        s_in_data  = d;
        s_in_tag   = t;
        check("s_rdy_idle", 64'(s_in_ready), 64'(1'b1));
        tick();
        s_in_valid = 1'b0;
        lat        = 0;
        busy_n     = 0;
        while (!s_out_valid && lat < 20) begin
            if (s_busy) busy_n++;
            tick();
            lat++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy_n;
        logic [5:0] g;

        rst_n       = 1'b0;
        p_in_valid  = 1'b0; p_in_data = '0; p_in_tag = '0; p_out_ready = 1'b1;
        s_in_valid  = 1'b0; s_in_data = '0; s_in_tag = '0; s_out_ready = 1'b1;
        #12;
        check("p_rst", 64'({p_out_valid, p_out_data, p_out_tag, p_busy, p_in_ready}),
              64'({1'b0, 32'h0, 4'h0, 1'b0, 1'b1}));
        check("s_rst", 64'({s_out_valid, s_out_data, s_out_tag, s_busy, s_in_ready}),
              64'({1'b0, 32'h0, 4'h0, 1'b0, 1'b1}));
        tick();
        rst_n = 1'b1;
        tick();

        // Parallel: all-zero, all-ones and half/half words, latency one edge.
        p_in_valid = 1'b1; p_in_data = 48'h0; p_in_tag = 4'h3;
        tick();
        p_in_valid = 1'b0;
        check("p_zero", 64'({p_out_valid, p_out_data, p_out_tag}), 64'({1'b1, 32'hEFA72C4D, 4'h3}));
        tick();
        check("p_drain", 64'(p_out_valid), 64'(1'b0));
        p_in_valid = 1'b1; p_in_data = 48'hFFFFFFFFFFFF; p_in_tag = 4'hA;
        tick();
        check("p_ones", 64'({p_out_valid, p_out_data, p_out_tag}), 64'({1'b1, 32'hD9CE3DCB, 4'hA}));
        p_in_data = 48'h000000FFFFFF; p_in_tag = 4'h6;
        tick();
        check("p_mixed", 64'({p_out_valid, p_out_data, p_out_tag}), 64'({1'b1, 32'hEFA73DCB, 4'h6}));

        // Parallel: S8 sweep back-to-back, no bubbles.
        for (int v = 0; v < 64; v++) begin
            g = 6'(v);
            p_in_data = {42'd0, g};
            check("p_sweep_rdy", 64'(p_in_ready), 64'(1'b1));
            tick();
            check("p_sweep", 64'({p_out_valid, p_out_data}),
                  64'({1'b1, 28'hEFA72C4, 4'(s8_tab[{g[5], g[0]}][g[4:1]])}));
        end
        p_in_valid = 1'b0;
        tick();

        // Parallel: backpressure holds the word, then simultaneous drain and load.
        p_out_ready = 1'b0;
        p_in_valid  = 1'b1; p_in_data = 48'h0; p_in_tag = 4'h1;
        tick();
        p_in_data = 48'hFFFFFFFFFFFF; p_in_tag = 4'h5;
        for (int i = 0; i < 5; i++) begin
            check("p_stall", 64'({p_in_ready, p_out_valid, p_out_data, p_out_tag}),
                  64'({1'b0, 1'b1, 32'hEFA72C4D, 4'h1}));
            tick();
        end
        p_out_ready = 1'b1;
        #1;
        check("p_rdy_release", 64'(p_in_ready), 64'(1'b1));
        tick();
        check("p_reload", 64'({p_out_valid, p_out_data, p_out_tag}), 64'({1'b1, 32'hD9CE3DCB, 4'h5}));
        p_in_valid = 1'b0;
        tick();
        check("p_empty", 64'(p_out_valid), 64'(1'b0));

        // Serial: the accept edge is the first of nine, so out_valid follows eight more edges.
        s_run(48'h0, 4'h2, lat, busy_n);
        check("s_zero_lat", 64'(lat), 64'(8));
        check("s_zero_busy", 64'(busy_n), 64'(8));
        check("s_zero", 64'({s_out_valid, s_busy, s_out_data, s_out_tag}),
              64'({1'b1, 1'b0, 32'hEFA72C4D, 4'h2}));
        tick();
        check("s_zero_drain", 64'({s_out_valid, s_in_ready}), 64'(2'b01));
        s_run(48'hFFFFFFFFFFFF, 4'hA, lat, busy_n);
        check("s_ones", 64'({s_out_valid, s_out_data, s_out_tag}), 64'({1'b1, 32'hD9CE3DCB, 4'hA}));
        tick();
        s_run(48'hFFFFFF000000, 4'h7, lat, busy_n);
        check("s_mixed", 64'({s_out_valid, s_out_data, s_out_tag}), 64'({1'b1, 32'hD9CE2C4D, 4'h7}));
        tick();

        // Serial: inputs blocked in RUN/DONE, outputs held under backpressure.
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1; s_in_data = 48'h0; s_in_tag = 4'h3;
        tick();
        s_in_data = 48'hFFFFFFFFFFFF; s_in_tag = 4'h9;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            check("s_block_run", 64'(s_in_ready), 64'(1'b0));
            tick();
            lat++;
        end
        check("s_block_lat", 64'(lat), 64'(8));
        for (int i = 0; i < 3; i++) begin
            check("s_hold", 64'({s_in_ready, s_out_valid, s_out_data, s_out_tag}),
                  64'({1'b0, 1'b1, 32'hEFA72C4D, 4'h3}));
            tick();
        end
        s_out_ready = 1'b1;
        tick();
        check("s_release", 64'({s_out_valid, s_in_ready}), 64'(2'b01));
        tick();
        check("s_next_acc", 64'({s_busy, s_in_ready}), 64'(2'b10));
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("s_next", 64'({s_out_valid, s_out_data, s_out_tag}), 64'({1'b1, 32'hD9CE3DCB, 4'h9}));
        tick();

        // Serial: asynchronous reset with the counter at 4.
        s_in_valid = 1'b1; s_in_data = 48'h0; s_in_tag = 4'h4;
        tick();
        s_in_valid = 1'b0;
        repeat (4) tick();
        check("s_busy_pre", 64'(s_busy), 64'(1'b1));
        #2 rst_n = 1'b0;
        #1;
        check("s_async_rst", 64'({s_out_valid, s_busy, s_out_data, s_in_ready}),
              64'({1'b0, 1'b0, 32'h0, 1'b1}));
        tick();
        rst_n = 1'b1;
        tick();
        check("s_post_idle", 64'({s_in_ready, s_out_valid}), 64'(2'b10));
        s_run(48'h0, 4'hC, lat, busy_n);
        check("s_post_lat", 64'(lat), 64'(8));
        check("s_post", 64'({s_out_valid, s_out_data, s_out_tag}), 64'({1'b1, 32'hEFA72C4D, 4'hC}));
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
